// File: rtl/team_08_tft_pkg.sv
// Shared types for the team_08 TFT link blocks.
// Word layout: DC flag above an MSB-first data byte.
package team_08_tft_pkg;

    localparam int TFT_WORD_W = 9;
    localparam int TFT_DC_BIT = 8;

    typedef logic [TFT_WORD_W-1:0] tft_word_t;

    typedef enum logic [0:0] {
        RX_IDLE   = 1'b0,
        RX_ACTIVE = 1'b1
    } rx_state_t;

endpackage

// File: rtl/team_08_tft_rx_if.sv
// Ready/valid stream of received TFT words.
// The receiver is the master; the consumer is the slave.
interface team_08_tft_rx_if;
    import team_08_tft_pkg::*;

    tft_word_t rx_data;
    logic      rx_valid;
    logic      rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/team_08_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and registered storage.
// A push while empty is visible one cycle later; no fall-through.
module team_08_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    // A full FIFO still accepts a write when the head leaves this cycle
    assign w_wr = i_push & (~o_full | i_pop);
    assign w_rd = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/team_08_tft_spi_rx.sv
// ILI9341 4-wire SPI responder: oversampled on clk, 9-bit words
// {DC, byte} buffered behind a ready/valid stream.
module team_08_tft_spi_rx
    import team_08_tft_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    en,
    input  logic                    tft_sck,
    input  logic                    tft_sdi,
    input  logic                    tft_dc,
    input  logic                    tft_cs,
    team_08_tft_rx_if.master        rx,
    output logic                    overflow,
    input  logic                    ovf_clr,
    output logic                    frame_err,
    output logic                    busy
);

    // Sync lanes packed as {cs, dc, sdi, sck}; cs idles inactive
    localparam logic [3:0] SYNC_RST = 4'b1000;

    genvar g;
    generate
        for (g = 0; g < SYNC_STAGES; g++) begin : g_sync
            logic [3:0] r_q;
            if (g == 0) begin : g_first
                always_ff @(posedge clk or negedge nrst) begin
                    if (!nrst) r_q <= SYNC_RST;
                    else       r_q <= {tft_cs, tft_dc, tft_sdi, tft_sck};
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge nrst) begin
                    if (!nrst) r_q <= SYNC_RST;
                    else       r_q <= g_sync[g-1].r_q;
                end
            end
        end
    endgenerate

    logic [3:0] w_sync;
    logic       w_sck;
    logic       w_sdi;
    logic       w_dc;
    logic       w_cs;

    assign w_sync = g_sync[SYNC_STAGES-1].r_q;
    assign w_sck  = w_sync[0];
    assign w_sdi  = w_sync[1];
    assign w_dc   = w_sync[2];
    assign w_cs   = w_sync[3];

    rx_state_t  r_state;
    logic       r_sck_prev;
    logic [2:0] r_bitcnt;
    logic [6:0] r_shift;
    logic       r_frame_err;
    logic       r_ovf;

    logic       w_rise;
    logic       w_cap;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_drop;
    tft_word_t  w_word;

    assign w_rise = w_sck & ~r_sck_prev;
    assign w_cap  = w_rise & en & ~w_cs;
    assign w_push = w_cap & (r_bitcnt == 3'd7);
    assign w_word = {w_dc, r_shift, w_sdi};
    assign w_pop  = rx.rx_valid & rx.rx_ready;
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= RX_IDLE;
            r_sck_prev  <= 1'b0;
            r_bitcnt    <= 3'd0;
            r_shift     <= 7'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_sck_prev  <= w_sck;
            r_frame_err <= 1'b0;
            unique case (1'b1)
                w_cs: begin
                    r_state     <= RX_IDLE;
                    r_bitcnt    <= 3'd0;
                    r_frame_err <= (r_state == RX_ACTIVE) &&
                                   (r_bitcnt != 3'd0);
                end
                default: begin
                    r_state <= RX_ACTIVE;
                    if (!en) begin
                        r_bitcnt <= 3'd0;
                    end else if (w_cap) begin
                        r_shift  <= {r_shift[5:0], w_sdi};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                end
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)        r_ovf <= 1'b0;
        else if (w_drop)  r_ovf <= 1'b1;
        else if (ovf_clr) r_ovf <= 1'b0;
    end

    team_08_sync_fifo #(
        .WIDTH (TFT_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .o_data  (rx.rx_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rx.rx_valid = ~w_empty;
    assign overflow    = r_ovf;
    assign frame_err   = r_frame_err;
    assign busy        = ~w_cs | (r_bitcnt != 3'd0);

endmodule

// File: tb/tb_team_08_tft_spi_rx.sv
// Bench for team_08_tft_spi_rx: vector table, directed corners
// and a random byte stream against a queue-based reference.
module tb_team_08_tft_spi_rx;

    logic clk = 1'b0;
    logic nrst;
    logic en;
    logic sck;
    logic sdi;
    logic dc;
    logic cs;
    logic ovf_clr;
    logic overflow;
    logic frame_err;
    logic busy;
    logic man_ready;
    logic rnd_ready;
    logic mon_en;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    logic [8:0] exp_q [$];

    team_08_tft_rx_if rx_if ();

    assign rx_if.rx_ready = mon_en ? rnd_ready : man_ready;

    team_08_tft_spi_rx #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .tft_sck   (sck),
        .tft_sdi   (sdi),
        .tft_dc    (dc),
        .tft_cs    (cs),
        .rx        (rx_if),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
    end

    always @(posedge clk) begin
        #1 rnd_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Random-phase consumer: every accepted word must match the model
    always @(negedge clk) begin
        if (mon_en && rx_if.rx_valid && rx_if.rx_ready) begin
            if (exp_q.size() == 0) check("rnd_extra_word", 1, 0);
            else check("rnd_word", 32'(rx_if.rx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic d);
        sck = 1'b0;
        sdi = b;
        dc  = d;
        repeat (4) tick();
        sck = 1'b1;
        repeat (4) tick();
    endtask

    task automatic send_bits(input logic [7:0] v, input logic d, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(v[i], d);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic d);
        send_bits(v, d, 8);
    endtask

    task automatic cs_low();
        sck = 1'b1;
        repeat (2) tick();
        cs = 1'b0;
        repeat (4) tick();
    endtask

    task automatic cs_high();
        sck = 1'b0;
        cs  = 1'b1;
        repeat (6) tick();
    endtask

    task automatic pop_check(input logic [8:0] exp, input string name);
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (rx_if.rx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_valid"}, 32'(ok), 1);
        if (ok) begin
            check({name, "_data"}, 32'(rx_if.rx_data), 32'(exp));
            man_ready = 1'b1;
            tick();
            man_ready = 1'b0;
        end
    endtask

    // Completes a byte with the pop timed onto the push edge
    task automatic send_byte_pop_last(input logic [7:0] v, input logic d,
                                      input logic [8:0] head);
        send_bits(v, d, 7);
        sck = 1'b0;
        sdi = v[0];
        dc  = d;
        repeat (4) tick();
        sck = 1'b1;
        tick();
        tick();
        check("t5_head_before", 32'(rx_if.rx_data), 32'(head));
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        repeat (2) tick();
    endtask

    typedef struct {
        logic [7:0] b;
        logic       d;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int fe0;
        int fe_exp;
        logic [7:0] rb;
        logic rd;
        int mode;

        vecs[0] = '{8'h2A, 1'b0, 9'h02A};
        vecs[1] = '{8'h00, 1'b1, 9'h100};
        vecs[2] = '{8'hEF, 1'b1, 9'h1EF};
        vecs[3] = '{8'hFF, 1'b0, 9'h0FF};
        vecs[4] = '{8'h80, 1'b1, 9'h180};
        vecs[5] = '{8'h01, 1'b0, 9'h001};

        nrst = 1'b0; en = 1'b1; sck = 1'b0; sdi = 1'b0; dc = 1'b0;
        cs = 1'b1; ovf_clr = 1'b0; man_ready = 1'b0; mon_en = 1'b0;
        rnd_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_data", 32'(rx_if.rx_data), 0);
        check("rst_valid", 32'(rx_if.rx_valid), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_fe", 32'(frame_err), 0);
        check("rst_busy", 32'(busy), 0);
        tick();
        nrst = 1'b1;
        repeat (4) tick();

        // Latency of the first word
        cs_low();
        check("t1_busy", 32'(busy), 1);
        send_bits(8'h2A, 1'b0, 7);
        sck = 1'b0; sdi = 1'b0; dc = 1'b0;
        repeat (4) tick();
        sck = 1'b1;
        @(negedge clk); check("t1_lat_e0", 32'(rx_if.rx_valid), 0);
        @(posedge clk); @(negedge clk);
        check("t1_lat_e1", 32'(rx_if.rx_valid), 0);
        @(posedge clk); @(negedge clk);
        check("t1_lat_e2", 32'(rx_if.rx_valid), 0);
        @(posedge clk); @(negedge clk);
        check("t1_lat_e3", 32'(rx_if.rx_valid), 1);
        check("t1_data", 32'(rx_if.rx_data), 32'h02A);
        repeat (2) tick();
        pop_check(9'h02A, "t1_pop");
        @(negedge clk);
        check("t1_empty", 32'(rx_if.rx_valid), 0);
        tick();

        // Table of bytes under one CS, SCK idling high in between
        fe0 = fe_cnt;
        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].b, vecs[i].d);
            pop_check(vecs[i].exp, $sformatf("vec%0d", i));
        end
        check("t2_no_fe", 32'(fe_cnt - fe0), 0);

        // Partial frame then a good byte
        fe0 = fe_cnt;
        send_bits(8'hC3, 1'b0, 5);
        cs_high();
        check("t3_fe_pulse", 32'(fe_cnt - fe0), 1);
        check("t3_no_word", 32'(rx_if.rx_valid), 0);
        cs_low();
        send_byte(8'h55, 1'b1);
        pop_check(9'h155, "t3_next");
        @(negedge clk);
        check("t3_empty", 32'(rx_if.rx_valid), 0);
        tick();

        // Overflow with a stalled consumer
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        repeat (4) tick();
        check("t4_ovf_set", 32'(overflow), 1);
        for (int i = 1; i <= 4; i++) pop_check(9'h100 | 9'(i), "t4_pop");
        @(negedge clk);
        check("t4_empty", 32'(rx_if.rx_valid), 0);
        check("t4_ovf_sticky", 32'(overflow), 1);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t4_ovf_clr", 32'(overflow), 0);

        // Full FIFO, push coincides with pop
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b0);
        send_byte_pop_last(8'h77, 1'b0, 9'h011);
        check("t5_no_ovf", 32'(overflow), 0);
        pop_check(9'h012, "t5_a");
        pop_check(9'h013, "t5_b");
        pop_check(9'h014, "t5_c");
        pop_check(9'h077, "t5_new");
        @(negedge clk);
        check("t5_empty", 32'(rx_if.rx_valid), 0);
        tick();

        // Reset in the middle of a byte with words queued
        fe0 = fe_cnt;
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        send_bits(8'hF0, 1'b1, 4);
        sck = 1'b0;
        repeat (4) tick();
        check("t6_queued", 32'(rx_if.rx_valid), 1);
        nrst = 1'b0;
        #3;
        check("t6_data", 32'(rx_if.rx_data), 0);
        check("t6_valid", 32'(rx_if.rx_valid), 0);
        check("t6_ovf", 32'(overflow), 0);
        check("t6_fe", 32'(frame_err), 0);
        check("t6_busy", 32'(busy), 0);
        repeat (2) tick();
        nrst = 1'b1;
        repeat (4) tick();
        send_byte(8'hA5, 1'b0);
        pop_check(9'h0A5, "t6_after");
        @(negedge clk);
        check("t6_empty", 32'(rx_if.rx_valid), 0);
        check("t6_no_fe", 32'(fe_cnt - fe0), 0);
        tick();

        // Random stream: good bytes, CS aborts, enable drops
        fe0 = fe_cnt;
        fe_exp = 0;
        mon_en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            mode = int'($urandom_range(0, 3));
            rb = 8'($urandom);
            rd = 1'($urandom);
            if (cs) cs_low();
            if (mode == 3) begin
                send_bits(rb, rd, int'($urandom_range(1, 7)));
                cs_high();
                fe_exp++;
            end else begin
                if (mode == 2) begin
                    send_bits(~rb, rd, int'($urandom_range(1, 7)));
                    en = 1'b0;
                    repeat (3) tick();
                    en = 1'b1;
                end
                exp_q.push_back({rd, rb});
                send_byte(rb, rd);
                if (mode == 1) cs_high();
            end
        end
        for (int t = 0; t < 500 && exp_q.size() != 0; t++) tick();
        check("rnd_drain", 32'(exp_q.size()), 0);
        mon_en = 1'b0;
        check("rnd_fe_count", 32'(fe_cnt - fe0), 32'(fe_exp));
        check("rnd_no_ovf", 32'(overflow), 0);
        if (cs) cs_low();
        cs_high();
        check("end_idle_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
